divisor_prog: RTL and testbench
===============================

// Module: divisor_prog
// PURPOSE
//  Parametrised, runtime-programmable clock divider: the next generation of the fixed 1-ratio divider.
//  Produces a 50%-duty square wave OUT and a 1-cycle TICK strobe per half-period.
//  Divide ratio is loadable at run time, glitch-free, via a shadow register applied only at a half-period boundary.
//  Feeds the Morse timing logic: dot/dash/gap unit rate selected by the speed setting.
// PARAMETERS
//  WIDTH        28          counter/ratio width; max half-period = 2^WIDTH-1 clocks
//  DEFAULT_HALF 50_000_000  half-period in CLK cycles after reset (1 Hz OUT at 100 MHz); must be < 2^WIDTH
// PORTS
//  CLK      in   1      system clock, rising edge
//  RST      in   1      asynchronous, active-high reset
//  EN       in   1      count enable; 0 = freeze counter, OUT, pending load
//  CLR      in   1      synchronous clear of counter and OUT (ratio kept)
//  HALF_IN  in   WIDTH  new half-period value in CLK cycles (0 treated as 1)
//  LOAD     in   1      1-cycle request: capture HALF_IN into shadow
//  PEND     out  1      shadow holds a value not yet applied
//  LOAD_ACK out  1      1-cycle pulse in the cycle the shadow value becomes active
//  TICK     out  1      1-cycle pulse, registered, each OUT toggle
//  OUT      out  1      divided square wave, period = 2*half clocks
// BEHAVIOUR
//  - Reset (async, any time incl. mid-period or with PEND=1): cnt=0, half_q=DEFAULT_HALF, shadow=0,
//    OUT=0, TICK=0, PEND=0, LOAD_ACK=0; pending load discarded.
//  - Terminal: term = EN & (cnt == half_q-1); half_q==1 -> term every enabled cycle (OUT = CLK/2).
//  - EN=1, !term: cnt<=cnt+1. On term: cnt<=0, OUT<=~OUT, TICK<=1 next cycle (all registered, 1-cycle latency).
//  - EN=0: cnt, OUT hold; TICK=0; no ratio update while frozen.
//  - CLR=1 (priority over count/term): cnt<=0, OUT<=0, TICK<=0; half_q, shadow, PEND unchanged.
//  - LOAD=1: shadow<=(HALF_IN==0 ? 1 : HALF_IN), PEND<=1. LOAD while PEND=1 overwrites shadow (last wins).
//  - Apply: on term with PEND=1 (set in an earlier cycle): half_q<=shadow, PEND<=0, LOAD_ACK<=1 for one cycle.
//    New ratio governs the very next half-period; the current half-period always completes at old ratio.
//  - LOAD and term in same cycle: term applies previous shadow if PEND was already 1, else nothing;
//    the newly captured value stays PEND and applies at the following term.
//  - CLR with PEND=1: load stays pending, applies at first term after clear.
//  - Wrap: cnt never exceeds half_q-1; if half_q shrinks it only changes at cnt=0, so no overrun possible.
//  - Widths: cnt, half_q, shadow all WIDTH bits, unsigned; compare via half_q-1 in WIDTH bits (half_q>=1 guaranteed).
// STRUCTURE
//  - Shared include divisor_defs.vh: CLK_HZ (100_000_000), DIV_WIDTH (28), Morse unit half-period constants
//    per speed setting (e.g. HALF_UNIT_SLOW/NORMAL/FAST).
//  - One sub-module: contador_mod (WIDTH) -- modulo counter with sync clear, enable, terminal value input,
//    registered-free TERM output. divisor_prog adds shadow/handshake, toggle FF, TICK/ACK registers.
// TESTING  (bench uses DEFAULT_HALF=4, WIDTH=8)
//  1 Reset release, EN=1 -> OUT toggles every 4 clocks, period 8; TICK pulse one cycle after each toggle edge.
//  2 HALF_IN=2, LOAD mid-period (cnt=1) -> PEND=1; current half finishes at 4; LOAD_ACK pulse; next halves of 2 clocks; PEND=0.
//  3 HALF_IN=0 loaded -> applied as 1; OUT toggles every enabled cycle; TICK continuously 1.
//  4 EN=0 for 10 cycles at cnt=2 -> OUT, cnt frozen, TICK=0, PEND held; EN=1 resumes, toggle 2 cycles later.
//  5 LOAD 6 then LOAD 3 before term -> only 3 applied, single LOAD_ACK; LOAD coincident with term -> applies one half later.
//  6 RST asserted asynchronously mid-period with PEND=1 -> all outputs 0 immediately; after release ratio = 4, PEND=0.

Source files
------------

// File: rtl/divisor_prog_pkg.sv
// Shared constants for the programmable divider and the Morse timing that sits on top of it.
package divisor_prog_pkg;

    localparam int unsigned CLK_HZ    = 100_000_000;
    localparam int unsigned DIV_WIDTH = 28;

    // Morse unit half-periods in CLK cycles (10 / 20 / 30 wpm at CLK_HZ)
    localparam int unsigned HALF_UNIT_SLOW   = 6_000_000;
    localparam int unsigned HALF_UNIT_NORMAL = 3_000_000;
    localparam int unsigned HALF_UNIT_FAST   = 2_000_000;

    typedef enum logic [1:0] {
        SPEED_SLOW   = 2'd0,
        SPEED_NORMAL = 2'd1,
        SPEED_FAST   = 2'd2
    } speed_e;

    function automatic logic [DIV_WIDTH-1:0] half_unit(input speed_e speed);
        logic [DIV_WIDTH-1:0] h;
        h = DIV_WIDTH'(HALF_UNIT_NORMAL);
        case (speed)
            SPEED_SLOW: h = DIV_WIDTH'(HALF_UNIT_SLOW);
            SPEED_FAST: h = DIV_WIDTH'(HALF_UNIT_FAST);
            default:    h = DIV_WIDTH'(HALF_UNIT_NORMAL);
        endcase
        return h;
    endfunction

endpackage

// File: rtl/divisor_prog_contador_mod.sv
// Modulo counter: wraps to 0 at term_val, sync clear, enable, combinational terminal flag.
module contador_mod #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] term_val,
    output logic             term_c
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Clear suppresses the terminal so nothing downstream toggles or applies a ratio.
    always_comb begin
        cnt_d  = cnt_q;
        term_c = en & ~clr & (cnt_q == term_val);
        if (clr) begin
            cnt_d = '0;
        end else if (term_c) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/divisor_prog.sv
// Runtime-programmable 50%-duty clock divider with a shadowed ratio applied at half-period boundaries.
module divisor_prog
    import divisor_prog_pkg::*;
#(
    parameter int unsigned WIDTH        = DIV_WIDTH,
    parameter int unsigned DEFAULT_HALF = 50_000_000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             CLR,
    input  logic [WIDTH-1:0] HALF_IN,
    input  logic             LOAD,
    output logic             PEND,
    output logic             LOAD_ACK,
    output logic             TICK,
    output logic             OUT
);

    logic [WIDTH-1:0] half_q, half_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic             ack_q, ack_d;
    logic             tick_q, tick_d;
    logic             out_q, out_d;
    logic [WIDTH-1:0] term_val_c;
    logic             term_c;

    assign term_val_c = half_q - WIDTH'(1);

    contador_mod #(
        .WIDTH(WIDTH)
    ) u_contador (
        .clk     (CLK),
        .rst     (RST),
        .en      (EN),
        .clr     (CLR),
        .term_val(term_val_c),
        .term_c  (term_c)
    );

    // A same-cycle LOAD lands in the shadow after the apply, so it waits for the next term.
    always_comb begin
        half_d   = half_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        ack_d    = 1'b0;
        tick_d   = term_c;
        out_d    = out_q;
        if (CLR) begin
            out_d = 1'b0;
        end else if (term_c) begin
            out_d = ~out_q;
        end
        if (term_c && pend_q) begin
            half_d = shadow_q;
            pend_d = 1'b0;
            ack_d  = 1'b1;
        end
        if (LOAD) begin
            shadow_d = (HALF_IN == '0) ? WIDTH'(1) : HALF_IN;
            pend_d   = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            half_q   <= WIDTH'(DEFAULT_HALF);
            shadow_q <= '0;
            pend_q   <= 1'b0;
            ack_q    <= 1'b0;
            tick_q   <= 1'b0;
            out_q    <= 1'b0;
        end else begin
            half_q   <= half_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            ack_q    <= ack_d;
            tick_q   <= tick_d;
            out_q    <= out_d;
        end
    end

    assign PEND     = pend_q;
    assign LOAD_ACK = ack_q;
    assign TICK     = tick_q;
    assign OUT      = out_q;

endmodule

// File: tb/tb_divisor_prog.sv
// Directed bench for divisor_prog with WIDTH=8, DEFAULT_HALF=4.
module tb_divisor_prog;

    logic       CLK;
    logic       RST;
    logic       EN;
    logic       CLR;
    logic [7:0] HALF_IN;
    logic       LOAD;
    logic       PEND;
    logic       LOAD_ACK;
    logic       TICK;
    logic       OUT;

    int total;
    int passed;

    divisor_prog #(
        .WIDTH(8),
        .DEFAULT_HALF(4)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .EN      (EN),
        .CLR     (CLR),
        .HALF_IN (HALF_IN),
        .LOAD    (LOAD),
        .PEND    (PEND),
        .LOAD_ACK(LOAD_ACK),
        .TICK    (TICK),
        .OUT     (OUT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Advance one rising edge; outputs are sampled and inputs changed 1 time unit later.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        total   = 0;
        passed  = 0;
        RST     = 1'b1;
        EN      = 1'b0;
        CLR     = 1'b0;
        LOAD    = 1'b0;
        HALF_IN = 8'd0;
        step();
        step();
        chk("rst_out",  32'(OUT), 32'd0);
        chk("rst_tick", 32'(TICK), 32'd0);
        chk("rst_pend", 32'(PEND), 32'd0);
        chk("rst_ack",  32'(LOAD_ACK), 32'd0);

        // 1: default half of 4
        RST = 1'b0;
        EN  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("t1_out",  32'(OUT),  32'((i >= 4) && (i <= 7)));
            chk("t1_tick", 32'(TICK), 32'((i == 4) || (i == 8)));
        end

        // 2: load 2 at cnt=1
        step();
        LOAD = 1'b1; HALF_IN = 8'd2;
        step();
        LOAD = 1'b0;
        chk("t2_pend_set", 32'(PEND), 32'd1);
        step();
        chk("t2_out_old", 32'(OUT), 32'd0);
        chk("t2_pend_hold", 32'(PEND), 32'd1);
        chk("t2_ack_early", 32'(LOAD_ACK), 32'd0);
        step();
        chk("t2_out_t", 32'(OUT), 32'd1);
        chk("t2_tick", 32'(TICK), 32'd1);
        chk("t2_ack", 32'(LOAD_ACK), 32'd1);
        chk("t2_pend_clr", 32'(PEND), 32'd0);
        step();
        chk("t2_ack_drop", 32'(LOAD_ACK), 32'd0);
        chk("t2_tick_drop", 32'(TICK), 32'd0);
        step();
        chk("t2_half2_a", 32'(OUT), 32'd0);
        chk("t2_tick2_a", 32'(TICK), 32'd1);
        step();
        chk("t2_mid", 32'(OUT), 32'd0);
        step();
        chk("t2_half2_b", 32'(OUT), 32'd1);

        // 3: load 0 -> half of 1
        LOAD = 1'b1; HALF_IN = 8'd0;
        step();
        LOAD = 1'b0;
        chk("t3_pend", 32'(PEND), 32'd1);
        step();
        chk("t3_out_t", 32'(OUT), 32'd0);
        chk("t3_ack", 32'(LOAD_ACK), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("t3_out", 32'(OUT), 32'(i % 2));
            chk("t3_tick", 32'(TICK), 32'd1);
        end

        // LOAD coincident with term while nothing pending: stays pending one half
        LOAD = 1'b1; HALF_IN = 8'd4;
        step();
        LOAD = 1'b0;
        chk("lt_pend", 32'(PEND), 32'd1);
        chk("lt_noack", 32'(LOAD_ACK), 32'd0);
        chk("lt_out", 32'(OUT), 32'd1);
        step();
        chk("lt_ack", 32'(LOAD_ACK), 32'd1);
        chk("lt_out2", 32'(OUT), 32'd0);

        // 4: freeze at cnt=2 with a pending load
        step();
        LOAD = 1'b1; HALF_IN = 8'd4;
        step();
        LOAD = 1'b0;
        EN   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t4_out_frz", 32'(OUT), 32'd0);
            chk("t4_tick_frz", 32'(TICK), 32'd0);
            chk("t4_pend_frz", 32'(PEND), 32'd1);
        end
        EN = 1'b1;
        step();
        chk("t4_resume1", 32'(OUT), 32'd0);
        step();
        chk("t4_resume2", 32'(OUT), 32'd1);
        chk("t4_tick", 32'(TICK), 32'd1);
        chk("t4_ack", 32'(LOAD_ACK), 32'd1);
        chk("t4_pend", 32'(PEND), 32'd0);

        // 5: load 6 then 3, last wins
        LOAD = 1'b1; HALF_IN = 8'd6;
        step();
        HALF_IN = 8'd3;
        step();
        LOAD = 1'b0;
        step();
        step();
        chk("t5_out_old", 32'(OUT), 32'd0);
        chk("t5_ack", 32'(LOAD_ACK), 32'd1);
        step();
        chk("t5_ack_once", 32'(LOAD_ACK), 32'd0);
        step();
        chk("t5_mid", 32'(OUT), 32'd0);
        LOAD = 1'b1; HALF_IN = 8'd2;
        step();
        LOAD = 1'b0;
        chk("t5_half3", 32'(OUT), 32'd1);
        chk("t5_co_noack", 32'(LOAD_ACK), 32'd0);
        chk("t5_co_pend", 32'(PEND), 32'd1);
        step();
        step();
        chk("t5_co_wait", 32'(OUT), 32'd1);
        step();
        chk("t5_co_apply", 32'(OUT), 32'd0);
        chk("t5_co_ack", 32'(LOAD_ACK), 32'd1);
        chk("t5_co_pend0", 32'(PEND), 32'd0);

        // 6: async reset mid-period with a pending load
        step();
        LOAD = 1'b1; HALF_IN = 8'd5;
        step();
        LOAD = 1'b0;
        chk("t6_pre_pend", 32'(PEND), 32'd1);
        chk("t6_pre_out", 32'(OUT), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        chk("t6_out", 32'(OUT), 32'd0);
        chk("t6_tick", 32'(TICK), 32'd0);
        chk("t6_pend", 32'(PEND), 32'd0);
        chk("t6_ack", 32'(LOAD_ACK), 32'd0);
        step();
        RST = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("t6_out_run", 32'(OUT), 32'(i == 4));
            chk("t6_pend_run", 32'(PEND), 32'd0);
        end

        // Synchronous clear drops OUT
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        chk("clr_out", 32'(OUT), 32'd0);
        chk("clr_tick", 32'(TICK), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
